// File: rtl/envelope_gen_pkg.sv
// Shared definitions for the ADSR envelope stage: stage encoding, default
// widths and the midpoint/full-scale helpers.
package envelope_gen_pkg;

  localparam int WAVE_DEPTH_DEF = 8;
  localparam int ENV_DEPTH_DEF  = 8;
  localparam int RATE_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    STAGE_IDLE    = 3'd0,
    STAGE_ATTACK  = 3'd1,
    STAGE_DECAY   = 3'd2,
    STAGE_SUSTAIN = 3'd3,
    STAGE_RELEASE = 3'd4
  } stage_e;

  function automatic int wave_mid(input int depth);
    return 32'sd1 << (depth - 32'sd1);
  endfunction

  function automatic int env_max(input int depth);
    return (32'sd1 << depth) - 32'sd1;
  endfunction

endpackage

// File: rtl/envelope_gen_if.sv
// Control, rate and sample bundle between the mixer side and the envelope stage.
interface envelope_gen_if #(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8,
  parameter int RATE_DEPTH = 8
);
  logic                  gate_i;
  logic                  tick_en_i;
  logic [RATE_DEPTH-1:0] attack_i;
  logic [RATE_DEPTH-1:0] decay_i;
  logic [ENV_DEPTH-1:0]  sustain_i;
  logic [RATE_DEPTH-1:0] release_i;
  logic [WAVE_DEPTH-1:0] wave_in_i;
  logic [WAVE_DEPTH-1:0] wave_out_o;
  logic [ENV_DEPTH-1:0]  envelope_o;
  logic [2:0]            stage_o;
  logic                  active_o;

  modport master (
    output gate_i, tick_en_i, attack_i, decay_i, sustain_i, release_i, wave_in_i,
    input  wave_out_o, envelope_o, stage_o, active_o
  );

  modport slave (
    input  gate_i, tick_en_i, attack_i, decay_i, sustain_i, release_i, wave_in_i,
    output wave_out_o, envelope_o, stage_o, active_o
  );
endinterface

// File: rtl/envelope_gen_scaler.sv
// Registered amplitude scaling of an offset-binary sample by the envelope level;
// kept separate so the multiply can be pipelined without touching the FSM.
module env_scaler
  import envelope_gen_pkg::*;
#(
  parameter int WAVE_DEPTH = WAVE_DEPTH_DEF,
  parameter int ENV_DEPTH  = ENV_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WAVE_DEPTH-1:0] wave_i,
  input  logic [ENV_DEPTH-1:0]  env_i,
  output logic [WAVE_DEPTH-1:0] wave_o
);
  localparam int P_W = WAVE_DEPTH + ENV_DEPTH + 2;
  localparam logic [WAVE_DEPTH-1:0] WAVE_MID = WAVE_DEPTH'(wave_mid(WAVE_DEPTH));
  localparam logic [ENV_DEPTH-1:0]  ENV_MAX  = ENV_DEPTH'(env_max(ENV_DEPTH));

  logic signed [WAVE_DEPTH:0] diff_s;
  logic signed [P_W-1:0]      diff_ext_s;
  logic signed [P_W-1:0]      env_ext_s;
  logic signed [P_W-1:0]      prod_s;
  logic [WAVE_DEPTH-1:0]      shifted_s;
  logic [WAVE_DEPTH-1:0]      wave_d;
  logic [WAVE_DEPTH-1:0]      wave_q;

  assign diff_s     = $signed({1'b0, wave_i}) - $signed({1'b0, WAVE_MID});
  assign diff_ext_s = P_W'(diff_s);
  assign env_ext_s  = $signed(P_W'(env_i));
  assign prod_s     = diff_ext_s * env_ext_s;
  assign shifted_s  = WAVE_DEPTH'(prod_s >>> ENV_DEPTH);

  // Full-scale envelope passes the sample through untouched.
  always_comb begin
    wave_d = WAVE_MID + shifted_s;
    if (env_i == ENV_MAX) begin
      wave_d = wave_i;
    end else begin
      wave_d = WAVE_MID + shifted_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wave_q <= WAVE_MID;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;
endmodule

// File: rtl/envelope_gen.sv
// Gated ADSR envelope: edge-captured trigger, tick-driven stage FSM and a
// registered sample scaler.
module envelope_gen
  import envelope_gen_pkg::*;
#(
  parameter int WAVE_DEPTH = WAVE_DEPTH_DEF,
  parameter int ENV_DEPTH  = ENV_DEPTH_DEF,
  parameter int RATE_DEPTH = RATE_DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  envelope_gen_if.slave bus
);
  localparam logic [ENV_DEPTH-1:0] ENV_MAX = ENV_DEPTH'(env_max(ENV_DEPTH));

  stage_e                  stage_q, stage_d, att_stage_s, rel_stage_s;
  logic [ENV_DEPTH-1:0]    env_q, env_d, att_env_s, rel_env_s;
  logic                    gate_q, trig_pend_q, trig_pend_d;
  logic                    active_q, active_d;
  logic                    rise_s, trig_s, att_full_s, dec_done_s, rel_done_s, releasable_s;
  logic [ENV_DEPTH:0]      att_sum_s;
  logic signed [ENV_DEPTH+1:0] dec_diff_s, rel_diff_s;

  assign rise_s = bus.gate_i & ~gate_q;
  assign trig_s = trig_pend_q | rise_s;

  assign att_sum_s   = {1'b0, env_q} + (ENV_DEPTH+1)'(bus.attack_i);
  assign att_full_s  = (bus.attack_i == RATE_DEPTH'(0)) || (att_sum_s >= {1'b0, ENV_MAX});
  assign att_env_s   = att_full_s ? ENV_MAX : att_sum_s[ENV_DEPTH-1:0];
  assign att_stage_s = att_full_s ? STAGE_DECAY : STAGE_ATTACK;

  // Differences are widened by two bits so underflow shows up as a negative value.
  assign dec_diff_s = $signed({2'b00, env_q}) - $signed((ENV_DEPTH+2)'(bus.decay_i));
  assign dec_done_s = (bus.decay_i == RATE_DEPTH'(0)) ||
                      (dec_diff_s <= $signed({2'b00, bus.sustain_i}));

  assign rel_diff_s  = $signed({2'b00, env_q}) - $signed((ENV_DEPTH+2)'(bus.release_i));
  assign rel_done_s  = (bus.release_i == RATE_DEPTH'(0)) || rel_diff_s[ENV_DEPTH+1] ||
                       (rel_diff_s == (ENV_DEPTH+2)'(0));
  assign rel_env_s   = rel_done_s ? ENV_DEPTH'(0) : rel_diff_s[ENV_DEPTH-1:0];
  assign rel_stage_s = rel_done_s ? STAGE_IDLE : STAGE_RELEASE;

  assign releasable_s = (stage_q == STAGE_ATTACK) || (stage_q == STAGE_DECAY) ||
                        (stage_q == STAGE_SUSTAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q     <= STAGE_IDLE;
      env_q       <= ENV_DEPTH'(0);
      gate_q      <= 1'b0;
      trig_pend_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      env_q       <= env_d;
      gate_q      <= bus.gate_i;
      trig_pend_q <= trig_pend_d;
      active_q    <= active_d;
    end
  end

  // Trigger beats note-off, which beats normal stage progression.
  always_comb begin
    stage_d     = stage_q;
    env_d       = env_q;
    trig_pend_d = trig_pend_q;
    if (bus.tick_en_i) begin
      trig_pend_d = 1'b0;
      if (trig_s) begin
        stage_d = att_stage_s;
        env_d   = att_env_s;
      end else if (!bus.gate_i && releasable_s) begin
        stage_d = rel_stage_s;
        env_d   = rel_env_s;
      end else begin
        case (stage_q)
          STAGE_IDLE:    env_d = ENV_DEPTH'(0);
          STAGE_ATTACK: begin
            stage_d = att_stage_s;
            env_d   = att_env_s;
          end
          STAGE_DECAY: begin
            if (dec_done_s) begin
              stage_d = STAGE_SUSTAIN;
              env_d   = bus.sustain_i;
            end else begin
              env_d   = dec_diff_s[ENV_DEPTH-1:0];
            end
          end
          STAGE_SUSTAIN: env_d = bus.sustain_i;
          STAGE_RELEASE: begin
            stage_d = rel_stage_s;
            env_d   = rel_env_s;
          end
          default: begin
            stage_d = STAGE_IDLE;
            env_d   = ENV_DEPTH'(0);
          end
        endcase
      end
    end else begin
      trig_pend_d = trig_pend_q | rise_s;
    end
  end

  always_comb begin
    active_d = (stage_d != STAGE_IDLE);
  end

  env_scaler #(
    .WAVE_DEPTH(WAVE_DEPTH),
    .ENV_DEPTH (ENV_DEPTH)
  ) u_scaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wave_i(bus.wave_in_i),
    .env_i (env_q),
    .wave_o(bus.wave_out_o)
  );

  assign bus.envelope_o = env_q;
  assign bus.stage_o    = stage_q;
  assign bus.active_o   = active_q;
endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen: stage sequencing, gate/trigger handling,
// asynchronous reset and sample scaling against hand-computed values.
module tb_envelope_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  envelope_gen_if #(.WAVE_DEPTH(8), .ENV_DEPTH(8), .RATE_DEPTH(8)) bus ();

  envelope_gen #(.WAVE_DEPTH(8), .ENV_DEPTH(8), .RATE_DEPTH(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] env_seq [12] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hEF, 8'hDF,
                               8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h80};
  logic [2:0] stg_seq [12] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                               3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
  logic [7:0] rel_seq [4]  = '{8'h60, 8'h40, 8'h20, 8'h00};

  initial begin
    bus.gate_i    = 1'b0;
    bus.tick_en_i = 1'b0;
    bus.attack_i  = 8'h40;
    bus.decay_i   = 8'h10;
    bus.sustain_i = 8'h80;
    bus.release_i = 8'h20;
    bus.wave_in_i = 8'h80;
    step(2);
    chk("reset_stage", bus.stage_o, 32'd0);
    chk("reset_env", bus.envelope_o, 32'h00);
    chk("reset_wave", bus.wave_out_o, 32'h80);
    chk("reset_active", bus.active_o, 32'd0);
    rst = 1'b0;
    step(1);

    // Attack then decay into sustain, ticking every clock
    bus.gate_i    = 1'b1;
    bus.tick_en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk($sformatf("ad_env_%0d", i), bus.envelope_o, 32'(env_seq[i]));
      chk($sformatf("ad_stage_%0d", i), bus.stage_o, 32'(stg_seq[i]));
    end
    chk("ad_active", bus.active_o, 32'd1);

    // Scaling at half level
    bus.wave_in_i = 8'hFF;
    step(1);
    chk("scale_80_ff", bus.wave_out_o, 32'hBF);
    bus.wave_in_i = 8'h00;
    step(1);
    chk("scale_80_00", bus.wave_out_o, 32'h40);

    // Release from sustain
    bus.gate_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("rel_env_%0d", i), bus.envelope_o, 32'(rel_seq[i]));
    end
    chk("rel_stage_end", bus.stage_o, 32'd0);
    chk("rel_active_end", bus.active_o, 32'd0);

    bus.wave_in_i = 8'hFF;
    step(1);
    chk("scale_00_ff", bus.wave_out_o, 32'h80);

    // Asynchronous reset in the middle of decay
    bus.gate_i = 1'b1;
    step(5);
    chk("pre_reset_stage", bus.stage_o, 32'd2);
    chk("pre_reset_env", bus.envelope_o, 32'hEF);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_stage", bus.stage_o, 32'd0);
    chk("async_rst_env", bus.envelope_o, 32'h00);
    chk("async_rst_wave", bus.wave_out_o, 32'h80);
    chk("async_rst_active", bus.active_o, 32'd0);
    bus.gate_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk("post_rst_stage", bus.stage_o, 32'd0);
    chk("post_rst_env", bus.envelope_o, 32'h00);

    // Short gate pulse between sparse ticks
    bus.tick_en_i = 1'b0;
    step(2);
    bus.gate_i = 1'b1;
    step(2);
    bus.gate_i = 1'b0;
    step(3);
    chk("pulse_no_tick", bus.stage_o, 32'd0);
    bus.tick_en_i = 1'b1;
    step(1);
    bus.tick_en_i = 1'b0;
    chk("pulse_stage", bus.stage_o, 32'd1);
    chk("pulse_env", bus.envelope_o, 32'h40);
    step(15);
    bus.tick_en_i = 1'b1;
    step(1);
    bus.tick_en_i = 1'b0;
    chk("pulse_rel_stage", bus.stage_o, 32'd4);
    chk("pulse_rel_env", bus.envelope_o, 32'h20);
    bus.tick_en_i = 1'b1;
    step(1);
    chk("pulse_idle", bus.stage_o, 32'd0);

    // Retrigger during release keeps the current level
    bus.gate_i = 1'b1;
    step(2);
    chk("rt_env_pre", bus.envelope_o, 32'h80);
    bus.gate_i    = 1'b0;
    bus.release_i = 8'h40;
    step(1);
    chk("rt_rel_stage", bus.stage_o, 32'd4);
    chk("rt_rel_env", bus.envelope_o, 32'h40);
    bus.gate_i   = 1'b1;
    bus.attack_i = 8'h20;
    step(1);
    chk("rt_stage", bus.stage_o, 32'd1);
    chk("rt_env", bus.envelope_o, 32'h60);

    // Zero release drains to idle, then zero attack jumps to full scale
    bus.gate_i    = 1'b0;
    bus.release_i = 8'h00;
    step(1);
    chk("rel0_env", bus.envelope_o, 32'h00);
    step(1);
    chk("rel0_stage", bus.stage_o, 32'd0);
    bus.gate_i   = 1'b1;
    bus.attack_i = 8'h00;
    step(1);
    chk("att0_env", bus.envelope_o, 32'hFF);
    chk("att0_stage", bus.stage_o, 32'd2);
    bus.tick_en_i = 1'b0;
    bus.wave_in_i = 8'h12;
    step(1);
    chk("scale_ff_bypass", bus.wave_out_o, 32'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
